// File: rtl/counter_run_arbiter.sv
// counter_run_arbiter: round-robin owner selection for one shared up-counter.
// A granted requester gets a run of count 0..len, then a single-cycle done pulse.
// The owner can abandon its run by dropping req; that returns to IDLE without a done pulse.
module counter_run_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   len,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [CW-1:0]        count,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     owner;
  logic [CW-1:0]     len_q;

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [PW-1:0]     off;
  logic [PW:0]       sum;
  logic [PW-1:0]     win;
  logic [CW-1:0]     win_len;
  logic              any_req;
  logic              owner_req;
  logic [PW-1:0]     nxt_ptr;

  // Winner search: rotate req so bit 0 is the ptr slot, take the lowest set bit,
  // then map the offset back to an absolute requester index.
  always_comb begin
    dbl     = {req, req} >> ptr;
    rot     = dbl[NREQ-1:0];
    any_req = 1'b0;
    off     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_req && rot[i]) begin
        any_req = 1'b1;
        off     = PW'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    win = (sum >= NREQ_W) ? PW'(sum - NREQ_W) : sum[PW-1:0];
  end

  // Length slice of the winner, selected by constant indices only.
  always_comb begin
    win_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == win) win_len = len[i*CW +: CW];
    end
  end

  // gnt is one-hot on the owner while running, so this is req[owner].
  assign owner_req = |(req & gnt);
  assign nxt_ptr   = (owner == PW'(NREQ-1)) ? '0 : owner + PW'(1);

  // Sequencer: IDLE arbitrates, RUN counts up to the latched length, DONE pulses once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      count <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
      owner <= '0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= RUN;
            owner <= win;
            len_q <= win_len;
            gnt   <= NREQ'(1) << win;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!owner_req) begin
            // Withdrawn: abandon the run quietly and move priority past the owner.
            state <= IDLE;
            gnt   <= '0;
            count <= '0;
            busy  <= 1'b0;
            ptr   <= nxt_ptr;
          end else if (count == len_q) begin
            state <= DONE;
            done  <= gnt;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= '0;
          gnt   <= '0;
          count <= '0;
          busy  <= 1'b0;
          ptr   <= nxt_ptr;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Structural invariants of the grant/done/count outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(gnt));
      assert ($onehot0(done));
      assert ((done & ~gnt) == '0);
      assert (!busy || (count <= len_q));
    end
  end

endmodule

// File: tb/tb_counter_run_arbiter.sv
// Directed bench for counter_run_arbiter: expected per-cycle outputs are queued
// when stimulus is applied and compared at each falling edge.
module tb_counter_run_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]   gnt, done;
  logic [CW-1:0]     count;
  logic              busy;

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] done;
    logic [2:0] count;
    logic       busy;
  } obs_t;

  typedef struct {
    obs_t       exp;
    logic [3:0] drop;   // req bits the requester releases after this sample
    string      tag;
  } sb_t;

  sb_t q[$];
  int  errors = 0;
  int  checks = 0;

  counter_run_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .len(len),
    .gnt(gnt), .done(done), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input obs_t e, input string tag);
    obs_t a;
    a = {gnt, done, count, busy};
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s: got gnt=%b done=%b count=%0d busy=%b, expected gnt=%b done=%b count=%0d busy=%b",
             tag, a.gnt, a.done, a.count, a.busy, e.gnt, e.done, e.count, e.busy);
    end
  endtask

  task automatic push(input obs_t e, input logic [3:0] drop, input string tag);
    sb_t s;
    s.exp = e; s.drop = drop; s.tag = tag;
    q.push_back(s);
  endtask

  task automatic push_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) push('0, 4'b0, tag);
  endtask

  // Full run: len+1 RUN cycles counting up, one DONE cycle, then one IDLE cycle.
  task automatic push_run(input int o, input int l, input logic [3:0] drop, input string tag);
    obs_t e;
    for (int i = 0; i <= l; i++) begin
      e = {4'(1 << o), 4'b0, 3'(i), 1'b1};
      push(e, 4'b0, $sformatf("%s_run%0d", tag, i));
    end
    e = {4'(1 << o), 4'(1 << o), 3'(l), 1'b1};
    push(e, drop, $sformatf("%s_done", tag));
    push_idle(1, $sformatf("%s_idle", tag));
  endtask

  task automatic drain_n(input int n);
    sb_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      @(negedge clk);
      s = q.pop_front();
      check(s.exp, s.tag);
      req = req & ~s.drop;
    end
  endtask

  task automatic drain();
    drain_n(q.size());
  endtask

  task automatic set_len(input int i, input int v);
    len[i*CW +: CW] = 3'(v);
  endtask

  initial begin
    obs_t e;
    rst_n = 1'b0;
    req   = '0;
    len   = '0;

    // Reset holds everything at zero.
    push_idle(2, "reset");
    drain();
    rst_n = 1'b1;
    push_idle(1, "idle_noreq");
    drain();

    // Round-robin with all requesting, len=1 each: 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    req = 4'b1111;
    push_run(0, 1, 4'b0000, "rr0");
    push_run(1, 1, 4'b0000, "rr1");
    push_run(2, 1, 4'b0000, "rr2");
    push_run(3, 1, 4'b0000, "rr3");
    push_run(0, 1, 4'b1111, "rr0b");
    push_idle(1, "rr_quiet");
    drain();

    // Single run on requester 2 with len 5.
    set_len(2, 5);
    req = 4'b0100;
    push_run(2, 5, 4'b0100, "single");
    push_idle(1, "single_quiet");
    drain();

    // len=0 and len=max boundaries.
    set_len(3, 0);
    req = 4'b1000;
    push_run(3, 0, 4'b1000, "len0");
    drain();
    set_len(0, 7);
    req = 4'b0001;
    push_run(0, 7, 4'b0001, "len7");
    drain();

    // Withdraw: requester 1 drops req at count=2; priority moves past it.
    set_len(1, 6);
    set_len(2, 1);
    set_len(0, 2);
    req = 4'b0111;
    push({4'b0010, 4'b0, 3'd0, 1'b1}, 4'b0000, "wd_run0");
    push({4'b0010, 4'b0, 3'd1, 1'b1}, 4'b0000, "wd_run1");
    push({4'b0010, 4'b0, 3'd2, 1'b1}, 4'b0010, "wd_run2");
    push_idle(1, "wd_abort");
    push_run(2, 1, 4'b0100, "wd_next2");
    push_run(0, 2, 4'b0001, "wd_next0");
    drain();

    // Owner's len changes after latching are ignored.
    set_len(1, 3);
    req = 4'b0010;
    push_run(1, 3, 4'b0010, "lenchg");
    drain_n(1);
    set_len(1, 7);
    drain();

    // Reset asserted mid-cycle during a run at count=3.
    set_len(2, 6);
    req = 4'b0100;
    for (int i = 0; i < 4; i++)
      push({4'b0100, 4'b0, 3'(i), 1'b1}, 4'b0000, $sformatf("rstrun%0d", i));
    drain();
    #2 rst_n = 1'b0;
    #1;
    e = '0;
    check(e, "async_reset");
    req = '0;
    push_idle(1, "in_reset");
    drain();
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    rst_n = 1'b1;
    req   = 4'b1111;
    push_run(0, 1, 4'b1111, "post_reset");
    push_idle(2, "end_quiet");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
